wb_monitor: RTL and testbench

WB_MONITOR -- requirements
Module: wb_monitor

---
 rtl/cpu_structs_pkg.sv | 26 ++
 rtl/wb_monitor_if.sv | 36 +++
 rtl/wb_wdog.sv | 50 +++++
 rtl/wb_monitor.sv | 165 ++++++++++++++++
 tb/tb_wb_monitor.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_structs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_structs_pkg
// Shared types for the writeback monitor: check codes (the code value is also
// the bit position in err_flags), monitor FSM states and the check count.
// ---------------------------------------------------------------------------
package cpu_structs_pkg;

    localparam int WB_NUM_CHK = 7;

    typedef enum logic [2:0] {
        CHK_RDY_HALT   = 3'd0,
        CHK_WR_NO_XFER = 3'd1,
        CHK_WR_NO_REQ  = 3'd2,
        CHK_ADDR_RANGE = 3'd3,
        CHK_X0_NONZERO = 3'd4,
        CHK_WAW        = 3'd5,
        CHK_TIMEOUT    = 3'd6
    } wb_chk_e;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRIPPED  = 2'd2
    } wb_mon_state_e;

endpackage

// File: rtl/wb_monitor_if.sv
// ---------------------------------------------------------------------------
// wb_monitor_if
// Per-channel memory-to-writeback and GPR write-port signals observed by the
// monitor. Arrays are indexed by writeback channel.
//   m2w_valid/m2w_rdy : memory stage beat; a beat is valid & rdy is not
//                       required here -- a "new write beat" is any cycle with
//                       m2w_valid & m2w_rd_wr, and m2w_rdy must never be high
//                       while the CPU is halted.
//   xfer_in/gpr_rd_wr : a GPR write (gpr_rd_wr) is only legal in a cycle with
//                       xfer_in high and m2w_rd_wr requesting it.
// modport master drives everything; modport slave (the monitor) only observes.
// ---------------------------------------------------------------------------
interface wb_monitor_if #(
    parameter int NUM_WB = 1,
    parameter int RSZ    = 32
) ();
    logic [NUM_WB-1:0]          m2w_valid;
    logic [NUM_WB-1:0]          m2w_rdy;
    logic [NUM_WB-1:0]          m2w_rd_wr;
    logic [NUM_WB-1:0]          xfer_in;
    logic [NUM_WB-1:0]          gpr_rd_wr;
    logic [NUM_WB-1:0][4:0]     m2w_rd_addr;
    logic [NUM_WB-1:0][4:0]     gpr_rd_addr;
    logic [NUM_WB-1:0][RSZ-1:0] m2w_rd_data;
    logic [NUM_WB-1:0][RSZ-1:0] gpr_rd_data;

    modport master (
        output m2w_valid, m2w_rdy, m2w_rd_wr, xfer_in, gpr_rd_wr,
        output m2w_rd_addr, gpr_rd_addr, m2w_rd_data, gpr_rd_data
    );

    modport slave (
        input m2w_valid, m2w_rdy, m2w_rd_wr, xfer_in, gpr_rd_wr,
        input m2w_rd_addr, gpr_rd_addr, m2w_rd_data, gpr_rd_data
    );
endinterface

// File: rtl/wb_wdog.sv
// ---------------------------------------------------------------------------
// wb_wdog
// Per-channel writeback watchdog. A write beat (start) arms the counter at 0;
// it counts every cycle until the channel's GPR write (done). expired is high
// in the cycle the counter is about to reach tmo_limit, so the registered flag
// in the parent lands tmo_limit+1 cycles after the beat. Fires once per beat.
// Ports:
//   clk_in, reset_in : clock, synchronous active-low reset
//   active           : monitor is checking; counter held at 0 otherwise
//   start, done      : beat seen / writeback seen on this channel
//   tmo_limit        : limit, 0 disables expiry
//   expired          : combinational timeout indication
// ---------------------------------------------------------------------------
module wb_wdog #(
    parameter int TMO_W = 8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             active,
    input  logic             start,
    input  logic             done,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             expired
);
    logic             running;
    logic [TMO_W-1:0] cnt;
    logic [TMO_W-1:0] cnt_inc;

    assign cnt_inc = cnt + TMO_W'(1);
    // A fresh beat or a completing writeback in the same cycle cancels expiry.
    assign expired = active && running && !start && !done &&
                     (tmo_limit != '0) && (cnt_inc == tmo_limit);

    always_ff @(posedge clk_in) begin
        if (!reset_in || !active) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            if (done || expired) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end
endmodule

// File: rtl/wb_monitor.sv
// ---------------------------------------------------------------------------
// wb_monitor
// Protocol checker for CPU writeback channels. Evaluates seven checks per
// channel each cycle, latches sticky flags one cycle later, captures the
// first error (lowest code, then lowest channel) and raises a one-cycle IRQ
// when the monitor trips.
// Ports:
//   clk_in, reset_in  : clock, synchronous active-low reset
//   mon_en, clr_in    : enable checking / clear captured errors
//   cpu_halt          : CPU halted (m2w_rdy must stay low)
//   wb                : per-channel writeback signals (slave modport)
//   x0_rd_data        : live value of GPR x0
//   tmo_limit         : watchdog limit (0 disables)
//   err_flags         : sticky flag per check code
//   err_code/err_chan : first error captured while ARMED
//   err_cnt           : cycles with at least one error, saturating
//   err_irq           : pulse on ARMED->TRIPPED
//   state_out         : FSM state
// ---------------------------------------------------------------------------
module wb_monitor
    import cpu_structs_pkg::*;
#(
    parameter int NUM_WB  = 1,
    parameter int MAX_GPR = 32,
    parameter int RSZ     = 32,
    parameter int TMO_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  mon_en,
    input  logic                  clr_in,
    input  logic                  cpu_halt,
    wb_monitor_if.slave           wb,
    input  logic [RSZ-1:0]        x0_rd_data,
    input  logic [TMO_W-1:0]      tmo_limit,
    output logic [WB_NUM_CHK-1:0] err_flags,
    output logic [2:0]            err_code,
    output logic [1:0]            err_chan,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  err_irq,
    output logic [1:0]            state_out
);
    localparam logic [5:0] GPR_LIM = 6'(MAX_GPR);

    wb_mon_state_e                     state;
    logic                              active;
    logic [WB_NUM_CHK-1:0][NUM_WB-1:0] chk;
    logic [WB_NUM_CHK-1:0]             flags_now;
    logic                              any_err;
    logic [2:0]                        first_code;
    logic [1:0]                        first_chan;
    logic                              found;
    logic [NUM_WB-1:0]                 tmo_hit;
    logic [NUM_WB-1:0]                 x0_wr_now;
    logic [NUM_WB-1:0]                 x0_wr_q;

    assign active    = mon_en && (state != ST_DISABLED);
    assign state_out = state;

    for (genvar g = 0; g < NUM_WB; g++) begin : g_wdog
        wb_wdog #(.TMO_W(TMO_W)) u_wdog (
            .clk_in    (clk_in),
            .reset_in  (reset_in),
            .active    (active),
            .start     (wb.m2w_valid[g] & wb.m2w_rd_wr[g]),
            .done      (wb.gpr_rd_wr[g]),
            .tmo_limit (tmo_limit),
            .expired   (tmo_hit[g])
        );
    end

    // Raw per-code, per-channel violations for the current cycle.
    always_comb begin
        chk       = '0;
        x0_wr_now = '0;
        if (active) begin
            for (int i = 0; i < NUM_WB; i++) begin
                x0_wr_now[i] = wb.gpr_rd_wr[i] && (wb.gpr_rd_addr[i] == 5'd0);
                chk[CHK_RDY_HALT][i]   = wb.m2w_rdy[i] & cpu_halt;
                chk[CHK_WR_NO_XFER][i] = wb.gpr_rd_wr[i] & ~wb.xfer_in[i];
                chk[CHK_WR_NO_REQ][i]  = wb.gpr_rd_wr[i] & ~wb.m2w_rd_wr[i];
                chk[CHK_ADDR_RANGE][i] = wb.m2w_valid[i] &
                                         ({1'b0, wb.m2w_rd_addr[i]} >= GPR_LIM);
                // x0 must read back as zero the cycle after anyone wrote it.
                chk[CHK_X0_NONZERO][i] = x0_wr_q[i] & (x0_rd_data != '0);
                chk[CHK_TIMEOUT][i]    = tmo_hit[i];
                for (int j = 0; j < NUM_WB; j++) begin
                    if ((j != i) && wb.gpr_rd_wr[i] && wb.gpr_rd_wr[j] &&
                        (wb.gpr_rd_addr[i] == wb.gpr_rd_addr[j]) &&
                        (wb.gpr_rd_addr[i] != 5'd0)) begin
                        chk[CHK_WAW][i] = 1'b1;
                    end
                end
            end
        end
    end

    // Collapse to flags and pick the winner: code order first, then channel.
    always_comb begin
        flags_now  = '0;
        first_code = '0;
        first_chan = '0;
        found      = 1'b0;
        for (int c = 0; c < WB_NUM_CHK; c++) begin
            flags_now[c] = |chk[c];
            for (int i = 0; i < NUM_WB; i++) begin
                if (!found && chk[c][i]) begin
                    found      = 1'b1;
                    first_code = 3'(c);
                    first_chan = 2'(i);
                end
            end
        end
    end

    assign any_err = |flags_now;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state     <= ST_DISABLED;
            err_flags <= '0;
            err_code  <= '0;
            err_chan  <= '0;
            err_cnt   <= '0;
            err_irq   <= 1'b0;
            x0_wr_q   <= '0;
        end else begin
            err_irq <= 1'b0;
            x0_wr_q <= x0_wr_now;
            // Clear beats a coincident error; that error is dropped.
            if (clr_in) begin
                err_flags <= '0;
                err_code  <= '0;
                err_chan  <= '0;
                err_cnt   <= '0;
            end else if (any_err) begin
                err_flags <= err_flags | flags_now;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
            case (state)
                ST_DISABLED: begin
                    if (mon_en) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!mon_en) begin
                        state <= ST_DISABLED;
                    end else if (any_err && !clr_in) begin
                        state    <= ST_TRIPPED;
                        err_irq  <= 1'b1;
                        err_code <= first_code;
                        err_chan <= first_chan;
                    end
                end
                ST_TRIPPED: begin
                    if (!mon_en)     state <= ST_DISABLED;
                    else if (clr_in) state <= ST_ARMED;
                end
                default: state <= ST_DISABLED;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_monitor.sv
// ---------------------------------------------------------------------------
// tb_wb_monitor
// Two monitor instances: A (one channel, default sizes) and B (two channels,
// 16 GPRs, 4-bit error counter). The driver pushes cycle-stamped expected
// output snapshots; the monitor process compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_monitor;

    localparam bit DUT_A = 1'b0;
    localparam bit DUT_B = 1'b1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        which;
        logic [6:0]  flags;
        logic [2:0]  code;
        logic [1:0]  chan;
        logic [15:0] cnt;
        logic        irq;
        logic [1:0]  st;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- DUT A ----------------
    logic        a_mon_en, a_clr, a_halt;
    logic [31:0] a_x0;
    logic [7:0]  a_tmo;
    logic [6:0]  a_flags;
    logic [2:0]  a_code;
    logic [1:0]  a_chan;
    logic [15:0] a_cnt;
    logic        a_irq;
    logic [1:0]  a_state;

    wb_monitor_if #(.NUM_WB(1), .RSZ(32)) if_a ();

    wb_monitor #(.NUM_WB(1)) u_a (
        .clk_in     (clk),
        .reset_in   (rst_n),
        .mon_en     (a_mon_en),
        .clr_in     (a_clr),
        .cpu_halt   (a_halt),
        .wb         (if_a),
        .x0_rd_data (a_x0),
        .tmo_limit  (a_tmo),
        .err_flags  (a_flags),
        .err_code   (a_code),
        .err_chan   (a_chan),
        .err_cnt    (a_cnt),
        .err_irq    (a_irq),
        .state_out  (a_state)
    );

    // ---------------- DUT B ----------------
    logic        b_mon_en, b_clr, b_halt;
    logic [31:0] b_x0;
    logic [7:0]  b_tmo;
    logic [6:0]  b_flags;
    logic [2:0]  b_code;
    logic [1:0]  b_chan;
    logic [3:0]  b_cnt;
    logic        b_irq;
    logic [1:0]  b_state;

    wb_monitor_if #(.NUM_WB(2), .RSZ(32)) if_b ();

    wb_monitor #(.NUM_WB(2), .MAX_GPR(16), .CNT_W(4)) u_b (
        .clk_in     (clk),
        .reset_in   (rst_n),
        .mon_en     (b_mon_en),
        .clr_in     (b_clr),
        .cpu_halt   (b_halt),
        .wb         (if_b),
        .x0_rd_data (b_x0),
        .tmo_limit  (b_tmo),
        .err_flags  (b_flags),
        .err_code   (b_code),
        .err_chan   (b_chan),
        .err_cnt    (b_cnt),
        .err_irq    (b_irq),
        .state_out  (b_state)
    );

    // ---------------- scoreboard ----------------
    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    int    mon_k;

    task automatic push_exp(input int d, input bit which, input string nm,
                            input logic [6:0] f, input logic [2:0] c,
                            input logic [1:0] ch, input logic [15:0] n,
                            input logic irq, input logic [1:0] st);
        exp_t e;
        e.cyc   = 32'(cyc + d);
        e.which = which;
        e.flags = f;
        e.code  = c;
        e.chan  = ch;
        e.cnt   = n;
        e.irq   = irq;
        e.st    = st;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_entry(input exp_t e, input string nm);
        logic [6:0]  f;
        logic [2:0]  c;
        logic [1:0]  ch;
        logic [15:0] n;
        logic        irq;
        logic [1:0]  st;
        if (e.which == DUT_A) begin
            f = a_flags; c = a_code; ch = a_chan; n = a_cnt; irq = a_irq; st = a_state;
        end else begin
            f = b_flags; c = b_code; ch = b_chan; n = {12'd0, b_cnt}; irq = b_irq; st = b_state;
        end
        n_vec++;
        if ({f, c, ch, n, irq, st} !== {e.flags, e.code, e.chan, e.cnt, e.irq, e.st}) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got flags=%02h code=%0d chan=%0d cnt=%0d irq=%0b state=%0d, expected flags=%02h code=%0d chan=%0d cnt=%0d irq=%0b state=%0d",
                     nm, cyc, f, c, ch, n, irq, st,
                     e.flags, e.code, e.chan, e.cnt, e.irq, e.st);
        end
    endtask

    always @(negedge clk) begin
        mon_k = 0;
        while (mon_k < exp_q.size()) begin
            if (exp_q[mon_k].cyc == 32'(cyc)) begin
                check_entry(exp_q[mon_k], name_q[mon_k]);
                exp_q.delete(mon_k);
                name_q.delete(mon_k);
            end else begin
                mon_k++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_a();
        if_a.m2w_valid = '0; if_a.m2w_rdy = '0; if_a.m2w_rd_wr = '0;
        if_a.xfer_in = '0; if_a.gpr_rd_wr = '0; if_a.m2w_rd_addr = '0;
        if_a.gpr_rd_addr = '0; if_a.m2w_rd_data = '0; if_a.gpr_rd_data = '0;
    endtask

    task automatic idle_b();
        if_b.m2w_valid = '0; if_b.m2w_rdy = '0; if_b.m2w_rd_wr = '0;
        if_b.xfer_in = '0; if_b.gpr_rd_wr = '0; if_b.m2w_rd_addr = '0;
        if_b.gpr_rd_addr = '0; if_b.m2w_rd_data = '0; if_b.gpr_rd_data = '0;
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data, input logic xfer);
        if_a.gpr_rd_wr[0] = 1'b1; if_a.m2w_rd_wr[0] = 1'b1; if_a.xfer_in[0] = xfer;
        if_a.gpr_rd_addr[0] = addr; if_a.gpr_rd_data[0] = data;
    endtask

    task automatic a_beat();
        if_a.m2w_valid[0] = 1'b1; if_a.m2w_rd_wr[0] = 1'b1;
    endtask

    task automatic clear_dut(input bit which, input string nm);
        if (which == DUT_A) a_clr = 1'b1; else b_clr = 1'b1;
        push_exp(1, which, nm, 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);
        a_clr = 1'b0; b_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_a(); idle_b();
        a_mon_en = 1'b1; a_clr = 1'b0; a_halt = 1'b0; a_x0 = '0; a_tmo = '0;
        b_mon_en = 1'b1; b_clr = 1'b0; b_halt = 1'b0; b_x0 = '0; b_tmo = '0;

        // Reset dominates mon_en.
        tick(3);
        push_exp(0, DUT_A, "reset_a", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        push_exp(0, DUT_B, "reset_b", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        push_exp(1, DUT_A, "arm_a", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        push_exp(1, DUT_B, "arm_b", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);

        // A: GPR write without xfer -> code 1, irq pulse, count 1.
        a_write(5'd3, 32'h1234, 1'b0);
        push_exp(1, DUT_A, "wr_no_xfer", 7'h02, 3'd1, 2'd0, 16'd1, 1'b1, 2'd2);
        tick(1);
        idle_a();
        push_exp(1, DUT_A, "wr_no_xfer_hold", 7'h02, 3'd1, 2'd0, 16'd1, 1'b0, 2'd2);
        tick(1);
        clear_dut(DUT_A, "clr_a1");

        // A: x0 written, reads back 0 -> fine; reads back DEAD -> code 4.
        a_write(5'd0, 32'hDEAD, 1'b1);
        tick(1);
        idle_a();
        push_exp(1, DUT_A, "x0_zero_ok", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);
        a_write(5'd0, 32'hDEAD, 1'b1);
        tick(1);
        idle_a();
        a_x0 = 32'hDEAD;
        push_exp(1, DUT_A, "x0_nonzero", 7'h10, 3'd4, 2'd0, 16'd1, 1'b1, 2'd2);
        tick(1);
        a_x0 = '0;
        clear_dut(DUT_A, "clr_a2");

        // A: watchdog limit 4 fires exactly 5 cycles after the beat, once.
        a_tmo = 8'd4;
        a_beat();
        push_exp(4, DUT_A, "tmo_early", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        push_exp(5, DUT_A, "tmo_fire", 7'h40, 3'd6, 2'd0, 16'd1, 1'b1, 2'd2);
        push_exp(7, DUT_A, "tmo_once", 7'h40, 3'd6, 2'd0, 16'd1, 1'b0, 2'd2);
        tick(1);
        idle_a();
        tick(8);
        clear_dut(DUT_A, "clr_a3");

        // A: writeback arriving before the limit cancels the watchdog.
        a_beat();
        push_exp(8, DUT_A, "tmo_done", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);
        idle_a();
        tick(1);
        a_write(5'd3, 32'h5, 1'b1);
        tick(1);
        idle_a();
        tick(7);

        // A: limit 0 disables the watchdog.
        a_tmo = 8'd0;
        a_beat();
        push_exp(5, DUT_A, "tmo_off5", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        push_exp(12, DUT_A, "tmo_off12", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);
        idle_a();
        tick(13);

        // A: no checking while disabled.
        a_mon_en = 1'b0;
        a_write(5'd3, 32'h7, 1'b0);
        push_exp(1, DUT_A, "disabled_gate", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        tick(1);
        idle_a();
        a_mon_en = 1'b1;
        push_exp(1, DUT_A, "rearm_a", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);

        // B: WAW on addr 5 -> code 5, chan 0.
        if_b.gpr_rd_wr = 2'b11; if_b.m2w_rd_wr = 2'b11; if_b.xfer_in = 2'b11;
        if_b.gpr_rd_addr[0] = 5'd5; if_b.gpr_rd_addr[1] = 5'd5;
        push_exp(1, DUT_B, "waw", 7'h20, 3'd5, 2'd0, 16'd1, 1'b1, 2'd2);
        tick(1);
        idle_b();
        clear_dut(DUT_B, "clr_b1");

        // B: both channels writing x0 is not WAW.
        if_b.gpr_rd_wr = 2'b11; if_b.m2w_rd_wr = 2'b11; if_b.xfer_in = 2'b11;
        push_exp(1, DUT_B, "waw_x0", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        push_exp(2, DUT_B, "waw_x0_next", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);
        idle_b();
        tick(1);

        // B: addr 15 in range; addr 17 plus code 1 on chan 1 -> code 1 wins.
        if_b.m2w_valid[0] = 1'b1; if_b.m2w_rd_addr[0] = 5'd15;
        push_exp(1, DUT_B, "addr15", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);
        if_b.m2w_rd_addr[0] = 5'd17;
        if_b.gpr_rd_wr[1] = 1'b1; if_b.m2w_rd_wr[1] = 1'b1; if_b.xfer_in[1] = 1'b0;
        if_b.gpr_rd_addr[1] = 5'd7;
        push_exp(1, DUT_B, "addr17_wr", 7'h0A, 3'd1, 2'd1, 16'd1, 1'b1, 2'd2);
        tick(1);
        idle_b();
        clear_dut(DUT_B, "clr_b2");

        // B: clear coincident with an error wins; error not re-seen later.
        b_halt = 1'b1; if_b.m2w_rdy[1] = 1'b1; b_clr = 1'b1;
        push_exp(1, DUT_B, "clr_wins", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);
        b_halt = 1'b0; idle_b(); b_clr = 1'b0;
        push_exp(1, DUT_B, "clr_wins_after", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd1);
        tick(1);

        // B: 19 error cycles saturate the 4-bit counter at 15.
        b_halt = 1'b1; if_b.m2w_rdy[1] = 1'b1;
        push_exp(1, DUT_B, "sat_first", 7'h01, 3'd0, 2'd1, 16'd1, 1'b1, 2'd2);
        push_exp(14, DUT_B, "sat_14", 7'h01, 3'd0, 2'd1, 16'd14, 1'b0, 2'd2);
        push_exp(16, DUT_B, "sat_top", 7'h01, 3'd0, 2'd1, 16'd15, 1'b0, 2'd2);
        push_exp(19, DUT_B, "sat_hold", 7'h01, 3'd0, 2'd1, 16'd15, 1'b0, 2'd2);
        tick(19);
        b_halt = 1'b0; idle_b();
        clear_dut(DUT_B, "sat_clr");

        // B: addr 16 is out of range; then reset while tripped.
        if_b.m2w_valid[0] = 1'b1; if_b.m2w_rd_addr[0] = 5'd16;
        push_exp(1, DUT_B, "addr16", 7'h08, 3'd3, 2'd0, 16'd1, 1'b1, 2'd2);
        tick(1);
        idle_b();
        push_exp(1, DUT_B, "trip_hold", 7'h08, 3'd3, 2'd0, 16'd1, 1'b0, 2'd2);
        tick(1);
        rst_n = 1'b0;
        push_exp(1, DUT_B, "rst_b", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        push_exp(1, DUT_A, "rst_a", 7'h00, 3'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        while (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: expectation for cyc %0d never checked", name_q[0], exp_q[0].cyc);
            exp_q.delete(0);
            name_q.delete(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
